e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, number of cycles Busy stays high for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of cycles Busy stays high for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port Start  input  1  E-stage holds an MDU instruction this cycle.
REQ-006 SHALL have port MDUOp  input  4  operation: mult, multu, div, divu, mthi, mtlo, mfhi, mflo, none.
REQ-007 SHALL have port Req  input  1  exception/interrupt flush; blocks new operations.
REQ-008 SHALL have port A  input  32  rs operand.
REQ-009 SHALL have port B  input  32  rt operand.
REQ-010 SHALL have port Busy  output  1  a multi-cycle operation is in flight.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.
REQ-013 SHALL have port Out  output  32  mfhi/mflo read data.

Function
REQ-014 SHALL accept an operation only on an edge where Start=1, Req=0 and Busy=0.
REQ-015 SHALL ignore Start with Busy=1: no state change, in-flight operation unaffected.
REQ-016 SHALL, on accepting mult/multu/div/divu: latch A and B, load the counter with MULT_CYCLES or DIV_CYCLES, and set Busy=1 after that edge.
REQ-017 SHALL decrement the counter on each edge while Busy=1.
REQ-018 SHALL, on the edge where the counter equals 1, write HI/LO from the latched operands, clear the counter and Busy; Busy is high exactly N cycles.
REQ-019 SHALL produce mult as a signed 64-bit product and multu as an unsigned 64-bit product, with HI=product[63:32] and LO=product[31:0].
REQ-020 SHALL produce div/divu with LO=quotient and HI=remainder, truncating toward zero; the remainder sign follows the dividend for div.
REQ-021 SHALL keep HI and LO unchanged at completion when the latched divisor is 0.
REQ-022 SHALL produce div 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-023 SHALL hold HI/LO at their old values while Busy=1, exposing no partial result.
REQ-024 SHALL, on an accepted mthi/mtlo, write A to HI/LO at that edge in one cycle without asserting Busy.
REQ-025 SHALL drive Out combinationally as HI for mfhi, LO for mflo, and 0 otherwise, regardless of Busy.
REQ-026 SHALL, with Req=1, suppress the start of any new operation including mthi/mtlo.
REQ-027 SHALL NOT abort an in-flight operation on Req: the op was issued by an older, committed instruction and completes normally.
REQ-028 SHALL treat the pipeline stall condition as (Start & MDU op) | Busy, computed outside this block from Busy.

Reset
REQ-029 SHALL, on reset assertion, immediately clear HI, LO, counter, latched operands and Busy to 0, independent of clk.
REQ-030 SHALL discard an operation in flight when reset is asserted mid-operation; no result is written after reset.
REQ-031 SHALL accept a Start on the first rising edge after reset deasserts.

Structure
REQ-032 SHALL define the MDUOp encodings in the shared macro.v next to the ALU op codes.
REQ-033 SHALL keep the default cycle counts MULT_CYCLES and DIV_CYCLES as module parameters, not in macro.v.
REQ-034 SHALL keep the arithmetic inline, with no sub-module; the counter/Busy logic is a two-state FSM (IDLE, BUSY) inside e_mdu.

Verification
REQ-035 SHALL cover mult: A=0xFFFFFFFE, B=3, Start for one cycle -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 SHALL cover multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
REQ-037 SHALL cover div: A=-7, B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; and div A=5, B=0 -> HI/LO unchanged.
REQ-038 SHALL cover a second Start during Busy, and an mthi with Req=1 -> both ignored; first result correct, HI not written.
REQ-039 SHALL cover reset asserted at cycle 3 of a div -> Busy, HI and LO are 0 immediately, with no write at the original completion cycle.
REQ-040 SHALL cover mtlo A=0x1234 then mflo the next cycle -> LO=0x1234 after one edge, Out=0x1234, Busy never asserted.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared E-stage op codes: ALU ops alongside the MDU op encodings.
// Also holds the MDU sequencer state type.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_LUI  = 4'd8
  } alu_op_e;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers.
// Results land in HI/LO only when the fixed-latency countdown expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam logic [15:0] MULT_N = 16'(MULT_CYCLES);
  localparam logic [15:0] DIV_N  = 16'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  mdu_op_e op_in;
  logic    accept;

  assign op_in  = mdu_op_e'(MDUOp);
  assign accept = Start & ~Req & (state_q == S_IDLE);

  // Low 64 bits of a product of sign-extended operands are the signed product.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'h0, a_q} * {32'h0, b_q};

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] q_mag, r_mag;
  logic [31:0] quot, rem;

  // Magnitude divide; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    a_neg = (op_q == MDU_DIV) & a_q[31];
    b_neg = (op_q == MDU_DIV) & b_q[31];
    a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    q_mag = 32'h0;
    r_mag = 32'h0;
    if (b_mag != 32'h0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_in)
            MDU_MULT, MDU_MULTU: begin
              op_d    = op_in;
              a_d     = A;
              b_d     = B;
              cnt_d   = MULT_N;
              state_d = S_BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              op_d    = op_in;
              a_d     = A;
              b_d     = B;
              cnt_d   = DIV_N;
              state_d = S_BUSY;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
          unique case (op_q)
            MDU_MULT: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            MDU_MULTU: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
              if (b_q != 32'h0) begin
                hi_d = rem;
                lo_d = quot;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= MDU_NONE;
      cnt_q   <= 16'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    Out = 32'h0;
    unique case (1'b1)
      (op_in == MDU_MFHI): Out = hi_q;
      (op_in == MDU_MFLO): Out = lo_q;
      default: ;
    endcase
  end

  assign Busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Randomized bench for e_mdu against an arithmetic HI/LO model.
// Directed cases cover the boundary scenarios of the unit.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic        Req = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        Busy;
  logic [31:0] HI, LO, Out;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  e_mdu dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
    .Req(Req), .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 clk = ~clk;

  function automatic int lat(input mdu_op_e op);
    if (op == MDU_MULT || op == MDU_MULTU) return 5;
    if (op == MDU_DIV || op == MDU_DIVU) return 10;
    return 0;
  endfunction

  function automatic void model(input mdu_op_e op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    longint p, sa, sb;
    logic [63:0] pu;
    case (op)
      MDU_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      MDU_MULTU: begin
        pu = {32'h0, a} * {32'h0, b};
        exp_hi = pu[63:32];
        exp_lo = pu[31:0];
      end
      MDU_DIV: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa / sb;
        exp_lo = p[31:0];
        p = sa % sb;
        exp_hi = p[31:0];
      end
      MDU_DIVU: if (b != 0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
      MDU_MTHI: exp_hi = a;
      MDU_MTLO: exp_lo = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input string nm);
    int n;
    logic [31:0] oh, ol;
    oh = HI;
    ol = LO;
    @(negedge clk);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE; A = $urandom; B = $urandom;
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      tests++;
      if (HI !== oh || LO !== ol) begin
        fails++;
        $display("FAIL %s partial: HI=%h LO=%h want %h %h", nm, HI, LO, oh, ol);
      end
      n++;
      @(negedge clk);
    end
    model(op, a, b);
    tests++;
    if (n != lat(op)) begin
      fails++;
      $display("FAIL %s busy_len: got %0d want %0d", nm, n, lat(op));
    end
    tests++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      fails++;
      $display("FAIL %s result: HI=%h LO=%h want %h %h", nm, HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (Busy !== 1'b0 || HI !== 0 || LO !== 0 || Out !== 0) begin
      fails++;
      $display("FAIL reset: Busy=%b HI=%h LO=%h Out=%h want 0", Busy, HI, LO, Out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, "mult");
    tests++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      fails++;
      $display("FAIL mult_const: HI=%h LO=%h want ffffffff fffffffa", HI, LO);
    end
    run_op(MDU_MULTU, 32'hFFFFFFFE, 32'd3, "multu");
    tests++;
    if (HI !== 32'h2 || LO !== 32'hFFFFFFFA) begin
      fails++;
      $display("FAIL multu_const: HI=%h LO=%h want 00000002 fffffffa", HI, LO);
    end
  endtask

  task automatic test_div();
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, "div");
    tests++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      fails++;
      $display("FAIL div_const: HI=%h LO=%h want ffffffff fffffffd", HI, LO);
    end
    run_op(MDU_DIV, 32'd5, 32'd0, "div_zero");
    run_op(MDU_DIVU, 32'd9, 32'd0, "divu_zero");
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    tests++;
    if (HI !== 32'h0 || LO !== 32'h80000000) begin
      fails++;
      $display("FAIL div_ovf_const: HI=%h LO=%h want 0 80000000", HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] a1, b1, oh, ol;
    a1 = $urandom;
    b1 = $urandom;
    oh = HI;
    ol = LO;
    @(negedge clk);
    Start = 1'b1; MDUOp = MDU_MULT; A = a1; B = b1;
    @(negedge clk);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      tests++;
      if (HI !== oh || LO !== ol) begin
        fails++;
        $display("FAIL b2b partial: HI=%h LO=%h want %h %h", HI, LO, oh, ol);
      end
      if (n == 0) begin
        MDUOp = MDU_DIV; A = $urandom; B = 32'd3;
      end else if (n == 1) begin
        MDUOp = MDU_MTHI; A = 32'hDEADBEEF;
      end else if (n == 2) begin
        Start = 1'b0; MDUOp = MDU_NONE; Req = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    Start = 1'b0; Req = 1'b0; MDUOp = MDU_NONE;
    model(MDU_MULT, a1, b1);
    tests++;
    if (n != 5) begin
      fails++;
      $display("FAIL b2b busy_len: got %0d want 5", n);
    end
    tests++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      fails++;
      $display("FAIL b2b result: HI=%h LO=%h want %h %h", HI, LO, exp_hi, exp_lo);
    end
    @(negedge clk);
    tests++;
    if (Busy !== 1'b0 || HI !== exp_hi) begin
      fails++;
      $display("FAIL b2b stray: Busy=%b HI=%h want 0 %h", Busy, HI, exp_hi);
    end
  endtask

  task automatic test_req();
    @(negedge clk);
    Req = 1'b1; Start = 1'b1; MDUOp = MDU_MTHI; A = 32'hCAFEF00D;
    @(negedge clk);
    tests++;
    if (HI !== exp_hi || Busy !== 1'b0) begin
      fails++;
      $display("FAIL req_mthi: HI=%h Busy=%b want %h 0", HI, Busy, exp_hi);
    end
    MDUOp = MDU_MULT; A = 32'd7; B = 32'd9;
    @(negedge clk);
    tests++;
    if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      fails++;
      $display("FAIL req_mult: Busy=%b HI=%h LO=%h want 0 %h %h", Busy, HI, LO, exp_hi, exp_lo);
    end
    Req = 1'b0; Start = 1'b0; MDUOp = MDU_NONE;
  endtask

  task automatic test_reset_mid();
    run_op(MDU_MTHI, 32'h11111111, 32'h0, "pre_mthi");
    run_op(MDU_MTLO, 32'h22222222, 32'h0, "pre_mtlo");
    @(negedge clk);
    Start = 1'b1; MDUOp = MDU_DIV; A = 32'hFFFFFFF9; B = 32'd2;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    tests++;
    if (Busy !== 1'b0 || HI !== 0 || LO !== 0) begin
      fails++;
      $display("FAIL reset_mid: Busy=%b HI=%h LO=%h want 0", Busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (Busy !== 1'b0 || HI !== 0 || LO !== 0) begin
      fails++;
      $display("FAIL reset_nowrite: Busy=%b HI=%h LO=%h want 0", Busy, HI, LO);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; Start = 1'b1; MDUOp = MDU_MTLO; A = 32'h0000ABCD;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    exp_lo = 32'h0000ABCD;
    tests++;
    if (LO !== exp_lo) begin
      fails++;
      $display("FAIL first_edge: LO=%h want %h", LO, exp_lo);
    end
  endtask

  task automatic test_mtlo_mflo();
    @(negedge clk);
    Start = 1'b1; MDUOp = MDU_MTLO; A = 32'h1234;
    @(negedge clk);
    exp_lo = 32'h1234;
    tests++;
    if (LO !== exp_lo || Busy !== 1'b0) begin
      fails++;
      $display("FAIL mtlo: LO=%h Busy=%b want 1234 0", LO, Busy);
    end
    MDUOp = MDU_MFLO;
    #1;
    tests++;
    if (Out !== 32'h1234) begin
      fails++;
      $display("FAIL mflo_out: Out=%h want 1234", Out);
    end
    MDUOp = MDU_MFHI;
    #1;
    tests++;
    if (Out !== exp_hi) begin
      fails++;
      $display("FAIL mfhi_out: Out=%h want %h", Out, exp_hi);
    end
    MDUOp = MDU_NONE;
    #1;
    tests++;
    if (Out !== 32'h0) begin
      fails++;
      $display("FAIL none_out: Out=%h want 0", Out);
    end
    @(negedge clk);
    Start = 1'b0;
    tests++;
    if (Busy !== 1'b0 || LO !== exp_lo) begin
      fails++;
      $display("FAIL mflo_side: Busy=%b LO=%h want 0 %h", Busy, LO, exp_lo);
    end
  endtask

  task automatic test_random();
    mdu_op_e ops[6];
    mdu_op_e op;
    logic [31:0] a, b;
    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 8);
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      run_op(op, a, b, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_req();
    test_reset_mid();
    test_mtlo_mflo();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
